// File: rtl/dclk_disp_pkg.sv
// Shared display constants for the digital clock: segment patterns,
// scan FSM state encodings and the default digit count.
package dclk_disp_pkg;

  localparam int NUM_DIGITS_DEF = 6;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BLANK = 2'b01,
    ST_DRIVE = 2'b10
  } scan_state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decode.
// Ports: i_bcd (4b digit), o_seg (7b {g,f,e,d,c,b,a}); 10-15 decode blank.
module bcd_to_seg7
  import dclk_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Multiplexed display scanner: steps select NUM_DIGITS-1..0, samples
// the muxed BCD digit after a blanking gap and drives active-low
// anodes/segments/dp. frame_tick pulses at the end of the digit-0 slot.
// Ports: clk, rst (async, high), en, bcd_in[3:0], dp_mask[5:0] in;
// select[3:0], an[5:0], seg[6:0], dp, frame_tick out.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zeros.
module digit_scan_ctrl
  import dclk_disp_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int NUM_DIGITS   = NUM_DIGITS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] bcd_in,
  input  logic [5:0] dp_mask,
  output logic [3:0] select,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [3:0]    SEL_TOP    = 4'(NUM_DIGITS - 1);

  scan_state_t   r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [3:0]    r_sel, w_sel_n;
  logic [6:0]    r_seg, w_seg_n;
  logic          r_dp, w_dp_n;
  logic [6:0]    w_seg_dec;
  logic          w_sample;
  logic          w_slot_end;

`ifdef LEADING_ZERO_BLANK_EN
  logic r_nz, w_nz_n;
  logic w_zero_sup;
`endif

  bcd_to_seg7 u_dec (
    .i_bcd (bcd_in),
    .o_seg (w_seg_dec)
  );

  assign w_sample   = (r_state == ST_BLANK) && (r_cnt == BLANK_LAST);
  assign w_slot_end = (r_state == ST_DRIVE) && (r_cnt == SLOT_LAST);

`ifdef LEADING_ZERO_BLANK_EN
  // Digit 0 is exempt so an all-zero value still shows one zero
  assign w_zero_sup = (bcd_in == 4'd0) && !r_nz && (r_sel != 4'd0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sel   <= SEL_TOP;
      r_seg   <= SEG_BLANK;
      r_dp    <= 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
      r_nz    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_sel   <= w_sel_n;
      r_seg   <= w_seg_n;
      r_dp    <= w_dp_n;
`ifdef LEADING_ZERO_BLANK_EN
      r_nz    <= w_nz_n;
`endif
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_sel_n   = r_sel;
    w_seg_n   = r_seg;
    w_dp_n    = r_dp;
`ifdef LEADING_ZERO_BLANK_EN
    w_nz_n    = r_nz;
`endif
    if (!en) begin
      // Dark display; the next enable restarts at the top digit
      w_state_n = ST_IDLE;
      w_cnt_n   = '0;
      w_sel_n   = SEL_TOP;
      w_seg_n   = SEG_BLANK;
      w_dp_n    = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
      w_nz_n    = 1'b0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_n = ST_BLANK;
        end
        ST_BLANK: begin
          w_cnt_n = r_cnt + 1'b1;
          if (w_sample) begin
            w_state_n = ST_DRIVE;
            w_seg_n   = w_seg_dec;
            w_dp_n    = ~dp_mask[r_sel[2:0]];
`ifdef LEADING_ZERO_BLANK_EN
            if (w_zero_sup)
              w_seg_n = SEG_BLANK;
            if (bcd_in != 4'd0)
              w_nz_n = 1'b1;
`endif
          end
        end
        ST_DRIVE: begin
          if (w_slot_end) begin
            w_state_n = ST_BLANK;
            w_cnt_n   = '0;
            w_sel_n   = (r_sel == 4'd0) ? SEL_TOP : r_sel - 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
            if (r_sel == 4'd0)
              w_nz_n = 1'b0;
`endif
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_n = ST_IDLE;
          w_cnt_n   = '0;
        end
      endcase
    end
  end

  assign select     = r_sel;
  assign an         = (r_state == ST_DRIVE) ? ~(6'b000001 << r_sel)
                                            : 6'h3F;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = w_slot_end && (r_sel == 4'd0) && en;

endmodule
